// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle carrying a control word and a payload between pipeline stages.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with stall (hold) and flush (bubble insert).
// Define PIPE_SKID_EN to add a one-entry skid buffer that cuts the ready path from downstream.
module pipe_stage_elastic #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 4,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  pipe_stage_elastic_if.slave  up,
  pipe_stage_elastic_if.master dn
);

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] data_p1;
  logic              rdy;
  logic              in_fire;
  logic              out_fire;

  // Bubbles always present CTRL_RST so a killed entry can never fire a side effect.
  assign dn.valid = vld_p1 & ~stall_i;
  assign dn.ctrl  = vld_p1 ? ctrl_p1 : CTRL_RST;
  assign dn.data  = data_p1;
  assign up.ready = rdy;

  assign out_fire = dn.valid & dn.ready;
  assign in_fire  = up.valid & rdy;

`ifdef PIPE_SKID_EN
  logic              skid_vld_p1;
  logic [CTRL_W-1:0] skid_ctrl_p1;
  logic [DATA_W-1:0] skid_data_p1;

  assign rdy = flush_i | (~stall_i & ~skid_vld_p1);

  // Stage register: main entry plus skid entry, drained strictly in FIFO order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= CTRL_RST;
      data_p1      <= '0;
      skid_vld_p1  <= 1'b0;
      skid_ctrl_p1 <= CTRL_RST;
      skid_data_p1 <= '0;
    end else if (flush_i) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= CTRL_RST;
      skid_vld_p1 <= 1'b0;
    end else if (!stall_i) begin
      if (out_fire && skid_vld_p1) begin
        vld_p1      <= 1'b1;
        ctrl_p1     <= skid_ctrl_p1;
        data_p1     <= skid_data_p1;
        skid_vld_p1 <= 1'b0;
      end else if (in_fire && (!vld_p1 || out_fire)) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= up.ctrl;
        data_p1 <= up.data;
      end else if (in_fire) begin
        skid_vld_p1  <= 1'b1;
        skid_ctrl_p1 <= up.ctrl;
        skid_data_p1 <= up.data;
      end else if (out_fire) begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= CTRL_RST;
      end
    end
  end
`else
  assign rdy = flush_i | (~stall_i & (~vld_p1 | dn.ready));

  // Stage register: single entry, refilled in the same cycle it drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_RST;
      data_p1 <= '0;
    end else if (flush_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_RST;
    end else if (!stall_i) begin
      if (in_fire) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= up.ctrl;
        data_p1 <= up.data;
      end else if (out_fire) begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= CTRL_RST;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomized bench for pipe_stage_elastic with a FIFO scoreboard of accepted entries.
// Works with PIPE_SKID_EN either defined or undefined.
module tb_pipe_stage_elastic;

`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] d;
  } ent_t;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;
  ent_t sb[$];

  pipe_stage_elastic_if #(.CTRL_W(4), .DATA_W(32)) up ();
  pipe_stage_elastic_if #(.CTRL_W(4), .DATA_W(32)) dn ();

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(4), .CTRL_RST(4'h0)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .up      (up.slave),
    .dn      (dn.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake mid-cycle, update scoreboard, advance past the edge.
  task automatic cycle();
    logic inf, outf, exp_v, exp_r;
    ent_t e;
    @(negedge clk_i);
    exp_v = (sb.size() > 0) && !stall_i;
    exp_r = flush_i || (!stall_i && ((sb.size() < CAP) || (CAP == 1 && dn.ready === 1'b1)));
    chk("valid_o", dn.valid, exp_v);
    chk("ready_o", up.ready, exp_r);
    inf  = up.valid & up.ready;
    outf = dn.valid & dn.ready;
    if (outf === 1'b1) begin
      delivered++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", dn.data, e.d);
        chk("sb_ctrl", dn.ctrl, e.c);
      end
    end
    if (flush_i) begin
      sb.delete();
    end else if (inf === 1'b1) begin
      e.c = up.ctrl;
      e.d = up.data;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int d0;
    int acc;
    logic rdy_exp [4];
    up.valid = 1'b0;
    up.ctrl  = 4'h0;
    up.data  = 32'h0;
    dn.ready = 1'b0;

    #2;
    chk("rst_valid_o", dn.valid, 0);
    chk("rst_ctrl_o", dn.ctrl, 0);
    chk("rst_data_o", dn.data, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Asynchronous reset with a valid entry held in the stage
    up.valid = 1'b1; up.ctrl = 4'h5; up.data = 32'h77;
    cycle();
    up.valid = 1'b0;
    chk("pre_rst_valid", dn.valid, 1);
    chk("pre_rst_ctrl", dn.ctrl, 4'h5);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", dn.valid, 0);
    chk("async_rst_ctrl", dn.ctrl, 0);
    chk("async_rst_data", dn.data, 0);
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Full-rate stream 0..7
    dn.ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      up.valid = 1'b1; up.data = i; up.ctrl = 4'(i);
      #1;
      chk("stream_ready", up.ready, 1);
      if (i > 0) chk("stream_nogap", dn.valid, 1);
      cycle();
    end
    up.valid = 1'b0;
    cycle();
    chk("stream_count", delivered - d0, 8);

    // Stall holds 0xAB, then delivers it exactly once
    up.valid = 1'b1; up.data = 32'hAB; up.ctrl = 4'h3;
    cycle();
    up.valid = 1'b0;
    stall_i  = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", up.ready, 0);
      chk("stall_valid", dn.valid, 0);
      chk("stall_data", dn.data, 32'hAB);
      cycle();
    end
    stall_i = 1'b0;
    cycle();
    cycle();
    chk("stall_once", delivered - d0, 1);

    // Flush together with stall kills the stage and the offered input
    dn.ready = 1'b0;
    up.valid = 1'b1; up.ctrl = 4'b1001; up.data = 32'h55;
    cycle();
    stall_i = 1'b1; flush_i = 1'b1;
    up.ctrl = 4'hF; up.data = 32'hDEAD;
    #1;
    chk("flush_ready", up.ready, 1);
    chk("flush_pre_ctrl", dn.ctrl, 4'b1001);
    cycle();
    stall_i = 1'b0; flush_i = 1'b0; up.valid = 1'b0;
    #1;
    chk("flush_valid", dn.valid, 0);
    chk("flush_ctrl", dn.ctrl, 0);
    dn.ready = 1'b1;
    d0 = delivered;
    cycle();
    cycle();
    chk("flush_nodeliver", delivered - d0, 0);

    // Backpressure with data 0x10, 0x11, ...
    dn.ready = 1'b0;
    acc = 0;
    rdy_exp[0] = 1'b1;
    rdy_exp[1] = (CAP == 2);
    rdy_exp[2] = 1'b0;
    rdy_exp[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      up.valid = 1'b1; up.ctrl = 4'h1; up.data = 32'h10 + acc;
      #1;
      chk("bp_ready", up.ready, rdy_exp[c]);
      if (up.ready === 1'b1) acc++;
      cycle();
    end
    dn.ready = 1'b1;
    d0 = delivered;
    for (int c = 0; c < 4; c++) begin
      if (acc < 2) begin
        up.valid = 1'b1; up.data = 32'h10 + acc;
        #1;
        if (up.ready === 1'b1) acc++;
      end else begin
        up.valid = 1'b0;
      end
      cycle();
    end
    up.valid = 1'b0;
    cycle();
    cycle();
    chk("bp_accepted", acc, 2);
    chk("bp_delivered", delivered - d0, 2);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      up.valid = 1'($urandom_range(0, 1));
      up.ctrl  = 4'($urandom);
      up.data  = $urandom;
      dn.ready = ($urandom_range(0, 99) < 70);
      stall_i  = ($urandom_range(0, 99) < 15);
      flush_i  = ($urandom_range(0, 99) < 5);
      cycle();
    end
    up.valid = 1'b0; stall_i = 1'b0; flush_i = 1'b0; dn.ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drain_empty", sb.size(), 0);
    chk("drain_valid", dn.valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
